frequency_generator: RTL and testbench

Parameterised clock divider deriving a slow, registered, 50 % duty-cycle square wave from the system clock. Used wherever a low-rate sampling or strobe clock is needed (e.g. the button debouncer samples its input on a 5 Hz output of this block). Output frequency is set at elaboration time from the input clock frequency and the requested output frequency.

---
 rtl/freqgen_pkg.sv | 22 ++
 rtl/freqgen_mod_counter.sv | 29 ++
 rtl/frequency_generator.sv | 68 ++++++
 tb/tb_frequency_generator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/freqgen_pkg.sv
// Shared helpers for frequency_generator: half-period math and range checks.
// The optional OutputTick port is enabled by defining FREQGEN_TICK_EN.
package freqgen_pkg;

  function automatic longint half_of(
    input longint fin,
    input longint fout
  );
    if (fout <= 0) return 0;
    return fin / (2 * fout);
  endfunction

  function automatic bit half_fits(
    input longint half,
    input int     bits
  );
    if (half <= 0) return 1'b0;
    if (bits >= 63) return 1'b1;
    return (half - 1) < (longint'(1) << bits);
  endfunction

endpackage

// File: rtl/freqgen_mod_counter.sv
// Modulo counter 0..LAST with enable, async active-low reset and wrap strobe.
// Used by frequency_generator (optional FREQGEN_TICK_EN tick lives in the top).
module freqgen_mod_counter
  import freqgen_pkg::*;
#(
  parameter int           W    = 30,
  parameter logic [W-1:0] LAST = '0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (o_wrap) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/frequency_generator.sv
// 50% duty clock divider: OutputCLK toggles every HALF enabled cycles.
// Define FREQGEN_TICK_EN to add the OutputTick rising-edge pulse.
module frequency_generator
  import freqgen_pkg::*;
#(
  parameter int inputFrequency = 50_000_000,
  parameter int frequency      = 1,
  parameter int bitsNumber     = 30
) (
  input  logic InputCLK,
  input  logic ResetN,
  input  logic Enable,
`ifdef FREQGEN_TICK_EN
  output logic OutputTick,
`endif
  output logic OutputCLK
);

  localparam longint HALF =
    half_of(longint'(inputFrequency),
            longint'(frequency));

  localparam logic [bitsNumber-1:0] LAST =
    bitsNumber'(HALF - 1);

  if (!half_fits(HALF, bitsNumber)) begin : g_bad_cfg
    $error("frequency_generator: HALF out of range");
  end

  logic w_wrap;
  logic r_clk;

  freqgen_mod_counter #(
    .W    (bitsNumber),
    .LAST (LAST)
  ) u_cnt (
    .i_clk   (InputCLK),
    .i_rst_n (ResetN),
    .i_en    (Enable),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge InputCLK or negedge ResetN) begin
    if (!ResetN) begin
      r_clk <= 1'b0;
    end else if (w_wrap) begin
      r_clk <= ~r_clk;
    end
  end

  assign OutputCLK = r_clk;

`ifdef FREQGEN_TICK_EN
  logic r_tick;

  // Pulse on the edge where the output flop goes 0->1.
  always_ff @(posedge InputCLK or negedge ResetN) begin
    if (!ResetN) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap && !r_clk;
    end
  end

  assign OutputTick = r_tick;
`endif

endmodule

// File: tb/tb_frequency_generator.sv
// Randomized bench for frequency_generator at HALF=5 and HALF=1.
// Reference: output = (enabled edges since reset / HALF) mod 2.
module tb_frequency_generator;

  logic clk;
  logic rst_n;
  logic en5;
  logic en1;
  logic o5;
  logic o1;
`ifdef FREQGEN_TICK_EN
  logic t5;
  logic t1;
`endif

  int total;
  int bad;
  int cyc;
  int n5;
  int n1;
  bit le5;
  bit le1;
  int rises5;
  int ticks5;
  logic prev5;

  frequency_generator #(
    .inputFrequency (20),
    .frequency      (2),
    .bitsNumber     (4)
  ) u_h5 (
    .InputCLK   (clk),
    .ResetN     (rst_n),
    .Enable     (en5),
`ifdef FREQGEN_TICK_EN
    .OutputTick (t5),
`endif
    .OutputCLK  (o5)
  );

  frequency_generator #(
    .inputFrequency (20),
    .frequency      (10),
    .bitsNumber     (2)
  ) u_h1 (
    .InputCLK   (clk),
    .ResetN     (rst_n),
    .Enable     (en1),
`ifdef FREQGEN_TICK_EN
    .OutputTick (t1),
`endif
    .OutputCLK  (o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input int    got,
    input int    want
  );
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               tag, cyc, got, want);
    end
  endtask

  task automatic check_outs();
    check("clk5", int'(o5), (n5 / 5) % 2);
    check("clk1", int'(o1), n1 % 2);
`ifdef FREQGEN_TICK_EN
    check("tick5", int'(t5),
          int'(le5 && (n5 % 10 == 5)));
    check("tick1", int'(t1),
          int'(le1 && (n1 % 2 == 1)));
    if (t5) ticks5++;
`endif
    if (!prev5 && o5) rises5++;
    prev5 = o5;
  endtask

  task automatic model_reset();
    n5 = 0;
    n1 = 0;
    le5 = 1'b0;
    le1 = 1'b0;
    prev5 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (en5) n5++;
    if (en1) n1++;
    le5 = en5;
    le1 = en1;
    #1;
    check_outs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rises5 = 0;
    ticks5 = 0;
    rst_n = 1'b0;
    en5 = 1'b1;
    en1 = 1'b1;
    model_reset();

    #12;
    check("rst_clk5", int'(o5), 0);
    check("rst_clk1", int'(o1), 0);
`ifdef FREQGEN_TICK_EN
    check("rst_tick5", int'(t5), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ten full periods, enable held high
    for (int i = 0; i < 100; i++) step();
    check("n5_period", n5, 100);

    // freeze at counter 3
    for (int i = 0; i < 3; i++) step();
    en5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("frozen5", int'(o5), 0);
    end
    en5 = 1'b1;
    step();
    check("resume1", int'(o5), 0);
    step();
    check("resume2", int'(o5), 1);

    // randomized enables on both dividers
    for (int i = 0; i < 300; i++) begin
      en5 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
      step();
    end

    // async reset with OutputCLK high and counter at 3
    en5 = 1'b1;
    en1 = 1'b1;
    for (int i = 0; i < 20 && (n5 % 10) != 8; i++)
      step();
    check("pre_rst_pos", n5 % 10, 8);
    check("pre_rst_clk", int'(o5), 1);
    rst_n = 1'b0;
    #1;
    check("async_clk5", int'(o5), 0);
`ifdef FREQGEN_TICK_EN
    check("async_tick5", int'(t5), 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("after_rst4", int'(o5), 0);
    step();
    check("after_rst5", int'(o5), 1);
    for (int i = 0; i < 40; i++) step();

    // more random traffic including enable gaps
    for (int i = 0; i < 200; i++) begin
      en5 = 1'($urandom_range(0, 3) != 0);
      en1 = 1'($urandom_range(0, 3) != 0);
      step();
    end

`ifdef FREQGEN_TICK_EN
    check("tick_count", ticks5, rises5);
`endif
    check("rises_seen", int'(rises5 > 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
